// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single AHB-Lite memory slave.
// Port 0 is normally the CPU and port 1 a DMA/video engine.
// When a live request loses arbitration, its address phase is parked in a
// per-port holding register. That master is then stalled with HREADYOUT low
// until the parked transfer is replayed and its data phase completes.
module ahb_ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  S0_HSEL,
    input  logic [ADDR_WIDTH-1:0] S0_HADDR,
    input  logic [1:0]            S0_HTRANS,
    input  logic [2:0]            S0_HSIZE,
    input  logic [3:0]            S0_HPROT,
    input  logic                  S0_HWRITE,
    input  logic [31:0]           S0_HWDATA,
    input  logic                  S0_HREADY,
    output logic                  S0_HREADYOUT,
    output logic [31:0]           S0_HRDATA,
    output logic                  S0_HRESP,

    input  logic                  S1_HSEL,
    input  logic [ADDR_WIDTH-1:0] S1_HADDR,
    input  logic [1:0]            S1_HTRANS,
    input  logic [2:0]            S1_HSIZE,
    input  logic [3:0]            S1_HPROT,
    input  logic                  S1_HWRITE,
    input  logic [31:0]           S1_HWDATA,
    input  logic                  S1_HREADY,
    output logic                  S1_HREADYOUT,
    output logic [31:0]           S1_HRDATA,
    output logic                  S1_HRESP,

    output logic                  M_HSEL,
    output logic [ADDR_WIDTH-1:0] M_HADDR,
    output logic [1:0]            M_HTRANS,
    output logic [2:0]            M_HSIZE,
    output logic [3:0]            M_HPROT,
    output logic                  M_HWRITE,
    output logic [31:0]           M_HWDATA,
    output logic                  M_HREADY,
    input  logic                  M_HREADYOUT,
    input  logic [31:0]           M_HRDATA,
    input  logic                  M_HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            size;
        logic [3:0]            prot;
        logic                  write;
    } aph_t;

    aph_t aph0_live, aph1_live, aph0, aph1, m_aph;
    aph_t hold0_q, hold0_d, hold1_q, hold1_d;
    logic pend0_q, pend0_d, pend1_q, pend1_d;
    logic own_vld_q, own_vld_d, own_id_q, own_id_d;
    logic last_grant_q, last_grant_d;
    logic live0, live1, cand0, cand1, granted, win;
    logic own0, own1;

    // HTRANS[0] (SEQ vs NONSEQ) is deliberately ignored: every beat is re-issued as NONSEQ.
    logic unused_htrans;
    assign unused_htrans = S0_HTRANS[0] ^ S1_HTRANS[0];

    assign live0 = S0_HSEL & S0_HTRANS[1] & S0_HREADY;
    assign live1 = S1_HSEL & S1_HTRANS[1] & S1_HREADY;

    assign aph0_live = '{addr: S0_HADDR, size: S0_HSIZE, prot: S0_HPROT, write: S0_HWRITE};
    assign aph1_live = '{addr: S1_HADDR, size: S1_HSIZE, prot: S1_HPROT, write: S1_HWRITE};

    // A parked transfer takes precedence; a port is never parked and live at once.
    assign aph0 = pend0_q ? hold0_q : aph0_live;
    assign aph1 = pend1_q ? hold1_q : aph1_live;

    // Pick the winner and drive the slave address phase.
    // When nobody requests, the address bus is parked on the last winner's source.
    always_comb begin
        cand0    = pend0_q | live0;
        cand1    = pend1_q | live1;
        granted  = cand0 | cand1;
        win      = last_grant_q;
        if (cand0 && cand1) begin
            win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else if (granted) begin
            win = cand1;
        end
        m_aph    = win ? aph1 : aph0;
        M_HSEL   = granted & HRESETn;
        M_HTRANS = (granted && HRESETn) ? HTRANS_NONSEQ : HTRANS_IDLE;
        M_HADDR  = m_aph.addr;
        M_HSIZE  = m_aph.size;
        M_HPROT  = m_aph.prot;
        M_HWRITE = m_aph.write;
    end

    // Next-state: grants move only when the slave is ready; live losers are always parked.
    always_comb begin
        pend0_d      = pend0_q;
        pend1_d      = pend1_q;
        hold0_d      = hold0_q;
        hold1_d      = hold1_q;
        own_vld_d    = own_vld_q;
        own_id_d     = own_id_q;
        last_grant_d = last_grant_q;
        if (M_HREADYOUT) begin
            own_vld_d = granted;
            own_id_d  = win;
            if (granted) begin
                last_grant_d = win;
                if (win) pend1_d = 1'b0;
                else     pend0_d = 1'b0;
            end
            if (live0 && win) begin
                pend0_d = 1'b1;
                hold0_d = aph0_live;
            end
            if (live1 && !win) begin
                pend1_d = 1'b1;
                hold1_d = aph1_live;
            end
        end else begin
            if (live0) begin
                pend0_d = 1'b1;
                hold0_d = aph0_live;
            end
            if (live1) begin
                pend1_d = 1'b1;
                hold1_d = aph1_live;
            end
        end
    end

    // State registers; reset drops every parked request and any data-phase ownership.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend0_q      <= 1'b0;
            pend1_q      <= 1'b0;
            hold0_q      <= '0;
            hold1_q      <= '0;
            own_vld_q    <= 1'b0;
            own_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            pend0_q      <= pend0_d;
            pend1_q      <= pend1_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
            own_vld_q    <= own_vld_d;
            own_id_q     <= own_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign own0 = own_vld_q & ~own_id_q;
    assign own1 = own_vld_q &  own_id_q;

    // Data phase: the owner sees the slave's ready/response, and a parked port is held off.
    assign S0_HREADYOUT = own0 ? M_HREADYOUT : ~pend0_q;
    assign S1_HREADYOUT = own1 ? M_HREADYOUT : ~pend1_q;
    assign S0_HRESP     = own0 & M_HRESP;
    assign S1_HRESP     = own1 & M_HRESP;
    assign S0_HRDATA    = M_HRDATA;
    assign S1_HRDATA    = M_HRDATA;
    assign M_HWDATA     = own_id_q ? S1_HWDATA : S0_HWDATA;
    assign M_HREADY     = M_HREADYOUT;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed bench for ahb_ram_arbiter. It uses a round-robin instance with a
// small RAM slave model, plus a fixed-priority instance driven on its own.
module tb_ahb_ram_arbiter;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;

    logic HCLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // round-robin instance
    logic        s0_sel, s0_write, s0_hready, s0_ro, s0_resp;
    logic [1:0]  s0_trans;
    logic [31:0] s0_addr, s0_wdata, s0_rdata;
    logic        s1_sel, s1_write, s1_hready, s1_ro, s1_resp;
    logic [1:0]  s1_trans;
    logic [31:0] s1_addr, s1_wdata, s1_rdata;
    logic [2:0]  sz = 3'b010;
    logic [3:0]  pr = 4'b0011;
    logic        m_hsel, m_hwrite, m_hready_o;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize;
    logic [3:0]  m_hprot;
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic        m_ready, m_resp;

    assign s0_hready = s0_ro;
    assign s1_hready = s1_ro;

    ahb_ram_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b0)) u_rr (
        .HCLK(HCLK), .HRESETn(rst_n),
        .S0_HSEL(s0_sel), .S0_HADDR(s0_addr), .S0_HTRANS(s0_trans), .S0_HSIZE(sz),
        .S0_HPROT(pr), .S0_HWRITE(s0_write), .S0_HWDATA(s0_wdata), .S0_HREADY(s0_hready),
        .S0_HREADYOUT(s0_ro), .S0_HRDATA(s0_rdata), .S0_HRESP(s0_resp),
        .S1_HSEL(s1_sel), .S1_HADDR(s1_addr), .S1_HTRANS(s1_trans), .S1_HSIZE(sz),
        .S1_HPROT(pr), .S1_HWRITE(s1_write), .S1_HWDATA(s1_wdata), .S1_HREADY(s1_hready),
        .S1_HREADYOUT(s1_ro), .S1_HRDATA(s1_rdata), .S1_HRESP(s1_resp),
        .M_HSEL(m_hsel), .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HSIZE(m_hsize),
        .M_HPROT(m_hprot), .M_HWRITE(m_hwrite), .M_HWDATA(m_hwdata), .M_HREADY(m_hready_o),
        .M_HREADYOUT(m_ready), .M_HRDATA(m_hrdata), .M_HRESP(m_resp)
    );

    // fixed-priority instance, always-ready slave
    logic        f0_sel, f1_sel, f0_ro, f1_ro, f0_resp, f1_resp;
    logic [1:0]  f0_trans, f1_trans, f_htrans;
    logic [31:0] f0_addr, f1_addr, f0_rdata, f1_rdata, f_haddr, f_hwdata;
    logic        f_hsel, f_hwrite, f_hready;
    logic [2:0]  f_hsize;
    logic [3:0]  f_hprot;

    ahb_ram_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b1)) u_fp (
        .HCLK(HCLK), .HRESETn(rst_n),
        .S0_HSEL(f0_sel), .S0_HADDR(f0_addr), .S0_HTRANS(f0_trans), .S0_HSIZE(sz),
        .S0_HPROT(pr), .S0_HWRITE(1'b0), .S0_HWDATA(32'h0), .S0_HREADY(f0_ro),
        .S0_HREADYOUT(f0_ro), .S0_HRDATA(f0_rdata), .S0_HRESP(f0_resp),
        .S1_HSEL(f1_sel), .S1_HADDR(f1_addr), .S1_HTRANS(f1_trans), .S1_HSIZE(sz),
        .S1_HPROT(pr), .S1_HWRITE(1'b0), .S1_HWDATA(32'h0), .S1_HREADY(f1_ro),
        .S1_HREADYOUT(f1_ro), .S1_HRDATA(f1_rdata), .S1_HRESP(f1_resp),
        .M_HSEL(f_hsel), .M_HADDR(f_haddr), .M_HTRANS(f_htrans), .M_HSIZE(f_hsize),
        .M_HPROT(f_hprot), .M_HWRITE(f_hwrite), .M_HWDATA(f_hwdata), .M_HREADY(f_hready),
        .M_HREADYOUT(1'b1), .M_HRDATA(32'h0), .M_HRESP(1'b0)
    );

    // RAM slave model: word index = HADDR[9:2], reset contents 0xA0000000 + index
    logic        dph_vld, dph_write;
    logic [7:0]  dph_idx;
    logic [31:0] mem [256];

    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            dph_vld   <= 1'b0;
            dph_write <= 1'b0;
            dph_idx   <= 8'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (m_hready_o) begin
            if (dph_vld && dph_write) mem[dph_idx] <= m_hwdata;
            dph_vld   <= m_hsel & m_htrans[1];
            dph_write <= m_hwrite;
            dph_idx   <= m_haddr[9:2];
        end
    end
    assign m_hrdata = (dph_vld && !dph_write) ? mem[dph_idx] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic [1:0] tr, input logic [31:0] a, input logic w);
        s0_sel = tr[1]; s0_trans = tr; s0_addr = a; s0_write = w;
    endtask

    task automatic drv1(input logic [1:0] tr, input logic [31:0] a, input logic w);
        s1_sel = tr[1]; s1_trans = tr; s1_addr = a; s1_write = w;
    endtask

    // stimulus/expectation tables
    logic [31:0] t3_a0 [8], t3_a1 [8], t3_m [8];
    logic        t3_n0 [8], t3_n1 [8], t3_r0 [8], t3_r1 [8];
    logic [31:0] tf_a0 [8], tf_a1 [8], tf_m [8];
    logic        tf_n0 [8], tf_r1 [8];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        t3_a0 = '{32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C, 32'h0, 32'h0};
        t3_n0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        t3_a1 = '{32'h200, 32'h204, 32'h204, 32'h208, 32'h208, 32'h20C, 32'h20C, 32'h0};
        t3_n1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t3_m  = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 32'h10C, 32'h20C};
        t3_r0 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        t3_r1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tf_a0 = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0, 32'h0, 32'h0};
        tf_n0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tf_a1 = '{32'h200, 32'h204, 32'h204, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C};
        tf_m  = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h208, 32'h20C};
        tf_r1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        drv0(ID, 32'h0, 1'b0); drv1(ID, 32'h0, 1'b0);
        s0_wdata = 32'h0; s1_wdata = 32'h0;
        f0_sel = 1'b0; f0_trans = ID; f0_addr = 32'h0;
        f1_sel = 1'b0; f1_trans = ID; f1_addr = 32'h0;
        m_ready = 1'b1; m_resp = 1'b0;

        // reset values
        @(negedge HCLK); #1;
        chk("rst_s0_ready", 32'(s0_ro), 32'h1);
        chk("rst_s1_ready", 32'(s1_ro), 32'h1);
        chk("rst_m_hsel", 32'(m_hsel), 32'h0);
        chk("rst_m_htrans", 32'(m_htrans), 32'h0);
        chk("rst_s0_resp", 32'(s0_resp), 32'h0);
        @(negedge HCLK); rst_n = 1'b1;

        // single master write then read
        @(negedge HCLK); drv0(NS, 32'h1000, 1'b1); #1;
        chk("t1_hsel", 32'(m_hsel), 32'h1);
        chk("t1_htrans", 32'(m_htrans), 32'h2);
        chk("t1_haddr", m_haddr, 32'h1000);
        chk("t1_hwrite", 32'(m_hwrite), 32'h1);
        chk("t1_hsize", 32'(m_hsize), 32'h2);
        chk("t1_s1_ready0", 32'(s1_ro), 32'h1);
        @(negedge HCLK); drv0(NS, 32'h1000, 1'b0); s0_wdata = 32'hDEADBEEF; #1;
        chk("t1_hwdata", m_hwdata, 32'hDEADBEEF);
        chk("t1_rd_hwrite", 32'(m_hwrite), 32'h0);
        chk("t1_rd_htrans", 32'(m_htrans), 32'h2);
        chk("t1_s0_ready1", 32'(s0_ro), 32'h1);
        chk("t1_s1_ready1", 32'(s1_ro), 32'h1);
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); #1;
        chk("t1_rdata", s0_rdata, 32'hDEADBEEF);
        chk("t1_s0_ready2", 32'(s0_ro), 32'h1);
        chk("t1_s1_ready2", 32'(s1_ro), 32'h1);
        chk("t1_idle_hsel", 32'(m_hsel), 32'h0);

        // same-cycle collision after reset: port 0 wins the first tie
        @(negedge HCLK); rst_n = 1'b0;
        @(negedge HCLK); rst_n = 1'b1;
        @(negedge HCLK); drv0(NS, 32'h10, 1'b0); drv1(NS, 32'h20, 1'b0); #1;
        chk("t2_haddr0", m_haddr, 32'h10);
        chk("t2_s1_ready0", 32'(s1_ro), 32'h1);
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); drv1(ID, 32'hBAD0, 1'b0); #1;
        chk("t2_haddr1", m_haddr, 32'h20);
        chk("t2_hsel1", 32'(m_hsel), 32'h1);
        chk("t2_s1_ready1", 32'(s1_ro), 32'h0);
        chk("t2_s0_ready1", 32'(s0_ro), 32'h1);
        chk("t2_s0_rdata", s0_rdata, 32'hA0000004);
        @(negedge HCLK); drv1(ID, 32'h0, 1'b0); #1;
        chk("t2_s1_ready2", 32'(s1_ro), 32'h1);
        chk("t2_s1_rdata", s1_rdata, 32'hA0000008);
        chk("t2_hsel2", 32'(m_hsel), 32'h0);

        // round-robin fairness with back-to-back reads
        for (int k = 0; k < 8; k++) begin
            @(negedge HCLK);
            drv0(t3_n0[k] ? NS : ID, t3_a0[k], 1'b0);
            drv1(t3_n1[k] ? NS : ID, t3_a1[k], 1'b0);
            #1;
            chk($sformatf("t3_haddr_%0d", k), m_haddr, t3_m[k]);
            chk($sformatf("t3_s0_ready_%0d", k), 32'(s0_ro), 32'(t3_r0[k]));
            chk($sformatf("t3_s1_ready_%0d", k), 32'(s1_ro), 32'(t3_r1[k]));
        end
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); drv1(ID, 32'h0, 1'b0); #1;
        chk("t3_hsel_end", 32'(m_hsel), 32'h0);
        chk("t3_s1_ready_end", 32'(s1_ro), 32'h1);
        chk("t3_s1_rdata", s1_rdata, 32'hA0000083);

        // fixed priority: every port-0 transfer precedes port 1
        for (int k = 0; k < 8; k++) begin
            @(negedge HCLK);
            f0_sel = tf_n0[k]; f0_trans = tf_n0[k] ? NS : ID; f0_addr = tf_a0[k];
            f1_sel = 1'b1; f1_trans = NS; f1_addr = tf_a1[k];
            #1;
            chk($sformatf("tf_haddr_%0d", k), f_haddr, tf_m[k]);
            chk($sformatf("tf_s0_ready_%0d", k), 32'(f0_ro), 32'h1);
            chk($sformatf("tf_s1_ready_%0d", k), 32'(f1_ro), 32'(tf_r1[k]));
        end
        @(negedge HCLK); f0_sel = 1'b0; f0_trans = ID; f1_sel = 1'b0; f1_trans = ID; #1;
        chk("tf_hsel_end", 32'(f_hsel), 32'h0);

        // slave wait states during a port-0 write while port 1 requests
        @(negedge HCLK); drv0(NS, 32'h300, 1'b1); #1;
        chk("t4_haddr0", m_haddr, 32'h300);
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); s0_wdata = 32'h12345678; m_ready = 1'b0;
        drv1(NS, 32'h304, 1'b0); s1_wdata = 32'h55AA55AA; #1;
        chk("t4_s0_ready1", 32'(s0_ro), 32'h0);
        chk("t4_s1_ready1", 32'(s1_ro), 32'h1);
        chk("t4_haddr1", m_haddr, 32'h304);
        chk("t4_hwdata1", m_hwdata, 32'h12345678);
        @(negedge HCLK); drv1(ID, 32'h0, 1'b0); #1;
        chk("t4_haddr2", m_haddr, 32'h304);
        chk("t4_htrans2", 32'(m_htrans), 32'h2);
        chk("t4_s0_ready2", 32'(s0_ro), 32'h0);
        chk("t4_s1_ready2", 32'(s1_ro), 32'h0);
        @(negedge HCLK); m_ready = 1'b1; #1;
        chk("t4_haddr3", m_haddr, 32'h304);
        chk("t4_hsel3", 32'(m_hsel), 32'h1);
        chk("t4_s0_ready3", 32'(s0_ro), 32'h1);
        chk("t4_s1_ready3", 32'(s1_ro), 32'h0);
        @(negedge HCLK); drv0(NS, 32'h300, 1'b0); #1;
        chk("t4_s1_ready4", 32'(s1_ro), 32'h1);
        chk("t4_s1_rdata", s1_rdata, 32'hA00000C1);
        chk("t4_hwdata4", m_hwdata, 32'h55AA55AA);
        chk("t4_haddr4", m_haddr, 32'h300);
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); #1;
        chk("t4_readback", s0_rdata, 32'h12345678);

        // two-cycle error on port 1 with port 0 parked behind it
        @(negedge HCLK); drv1(NS, 32'h400, 1'b0); #1;
        chk("t5_haddr0", m_haddr, 32'h400);
        @(negedge HCLK); drv1(ID, 32'h0, 1'b0); drv0(NS, 32'h404, 1'b0);
        m_ready = 1'b0; m_resp = 1'b1; #1;
        chk("t5_s1_resp1", 32'(s1_resp), 32'h1);
        chk("t5_s0_resp1", 32'(s0_resp), 32'h0);
        chk("t5_s1_ready1", 32'(s1_ro), 32'h0);
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); m_ready = 1'b1; #1;
        chk("t5_s1_resp2", 32'(s1_resp), 32'h1);
        chk("t5_s1_ready2", 32'(s1_ro), 32'h1);
        chk("t5_s0_resp2", 32'(s0_resp), 32'h0);
        chk("t5_s0_ready2", 32'(s0_ro), 32'h0);
        chk("t5_haddr2", m_haddr, 32'h404);
        chk("t5_hsel2", 32'(m_hsel), 32'h1);
        @(negedge HCLK); m_resp = 1'b0; #1;
        chk("t5_s0_ready3", 32'(s0_ro), 32'h1);
        chk("t5_s0_rdata", s0_rdata, 32'hA0000001);
        chk("t5_s1_resp3", 32'(s1_resp), 32'h0);

        // reset with port 1 parked behind a stalled port-0 read
        @(negedge HCLK); drv0(NS, 32'h500, 1'b0); #1;
        chk("t6_haddr0", m_haddr, 32'h500);
        @(negedge HCLK); drv0(ID, 32'h0, 1'b0); drv1(NS, 32'h504, 1'b0); m_ready = 1'b0; #1;
        chk("t6_s1_ready1", 32'(s1_ro), 32'h1);
        chk("t6_s0_ready1", 32'(s0_ro), 32'h0);
        @(negedge HCLK); rst_n = 1'b0; drv0(NS, 32'h508, 1'b0); drv1(ID, 32'h0, 1'b0); #1;
        chk("t6_rst_hsel", 32'(m_hsel), 32'h0);
        chk("t6_rst_htrans", 32'(m_htrans), 32'h0);
        chk("t6_rst_s0_ready", 32'(s0_ro), 32'h1);
        chk("t6_rst_s1_ready", 32'(s1_ro), 32'h1);
        @(negedge HCLK); rst_n = 1'b1; drv0(ID, 32'h0, 1'b0); m_ready = 1'b1; #1;
        chk("t6_post_hsel", 32'(m_hsel), 32'h0);
        chk("t6_post_s1_ready", 32'(s1_ro), 32'h1);
        @(negedge HCLK); #1;
        chk("t6_noreplay_hsel", 32'(m_hsel), 32'h0);
        chk("t6_noreplay_s1_ready", 32'(s1_ro), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_ram_arbiter.md
Name: ahb_ram_arbiter

Overview:
- Two-master AHB-Lite arbiter that shares one single-slave AHB-Lite memory port between requesters.
- Typical use: the block RAM slave shared between CPU (port 0) and a DMA/video engine (port 1).
- Each port appears to its master as an ordinary AHB-Lite slave.
- A transfer that loses arbitration is captured in a per-port holding register, and that master is stalled with HREADYOUT low until its transfer is replayed and its data phase completes.

Parameters:
- ADDR_WIDTH, 32, width of all HADDR buses.
- FIXED_PRIO, 0; 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset: asynchronous, active-low.
- Sx_HSEL  in  1  port x (x = 0, 1) select.
- Sx_HADDR  in  ADDR_WIDTH  port x address.
- Sx_HTRANS  in  2  port x transfer type.
- Sx_HSIZE  in  3  port x size.
- Sx_HPROT  in  4  port x protection.
- Sx_HWRITE  in  1  port x direction.
- Sx_HWDATA  in  32  port x write data.
- Sx_HREADY  in  1  port x bus ready; equals Sx_HREADYOUT in a point-to-point hookup.
- Sx_HREADYOUT  out  1  port x ready to its master.
- Sx_HRDATA  out  32  port x read data; M_HRDATA broadcast to both ports.
- Sx_HRESP  out  1  port x error response.
- M_HSEL  out  1  select to slave.
- M_HADDR  out  ADDR_WIDTH  address to slave.
- M_HTRANS  out  2  transfer type to slave.
- M_HSIZE  out  3  size to slave.
- M_HPROT  out  4  protection to slave.
- M_HWRITE  out  1  direction to slave.
- M_HWDATA  out  32  write data to slave.
- M_HREADY  out  1  ready to slave; equals M_HREADYOUT.
- M_HREADYOUT  in  1  slave ready.
- M_HRDATA  in  32  slave read data.
- M_HRESP  in  1  slave error response.

Behaviour:
Request detection:
- Live request on port x: live_x = Sx_HSEL & Sx_HTRANS[1] & Sx_HREADY.

State:
- pend_x flag per port, plus captured HADDR/HSIZE/HPROT/HWRITE.
- last_grant (1 bit).
- own_vld / own_id: data-phase owner.

Reset values (all state):
- pend_x = 0, own_vld = 0, own_id = 0, last_grant = 1, so port 0 wins the first tie.

Outputs while HRESETn low:
- M_HSEL = 0, M_HTRANS = IDLE.
- Sx_HREADYOUT = 1, Sx_HRESP = 0.

Arbitration:
- Evaluated only in cycles where M_HREADYOUT = 1.
- Candidate x = pend_x | live_x.
- Both candidates: FIXED_PRIO = 1 picks port 0; otherwise pick the port not equal to last_grant.
- Winner's address phase drives M_*: taken from the holding register if pend_x, else combinationally from the live Sx_* inputs.
- M_HSEL = 1, M_HTRANS forced to NONSEQ (2'b10). SEQ beats are re-issued as NONSEQ because beats from the two masters may interleave.
- No candidate: M_HSEL = 0, M_HTRANS = IDLE, other M_* don't-care (hold last).

On clock edge with M_HREADYOUT = 1:
- Winner's pend clears.
- own_vld <= granted, own_id <= winner, last_grant <= winner when granted.
- A live loser sets pend and captures its address-phase signals.

With M_HREADYOUT = 0:
- No new grant, no state change.
- Live requests still sampled; a live_x arriving while the slave is stalled is captured into pend_x.

Data phase:
- M_HWDATA = S[own_id]_HWDATA.
- Sx_HREADYOUT:
  - = M_HREADYOUT when own_vld & own_id == x;
  - else 0 if pend_x;
  - else 1.
- Sx_HRESP = M_HRESP when own_vld & own_id == x, else 0. Both error cycles are forwarded.
- The pending port's master holds HWDATA stable while stalled, so replayed writes use correct data.

Latency:
- Uncontended: zero added cycles; live inputs pass combinationally.
- Contended loser: stalled one extra data-phase length per competing transfer.
- Round-robin bound: at most one foreign transfer before the pending transfer is granted.

Boundary cases:
- Owner issues a new address while its data phase completes: legal, and arbitrated in the same cycle.
- Port never both pend and live: its HREADY is low while pend.
- Error to owner: no effect on the other port's pending request.
- Reset mid-transfer: all pend and ownership dropped immediately.

Test Plan:
- Single master: S0 write 0x1000 = 0xDEADBEEF, then read 0x1000 -> M_HTRANS = NONSEQ in the same cycle, S0_HREADYOUT stays 1, S0_HRDATA = 0xDEADBEEF, S1_HREADYOUT = 1 throughout.
- Same-cycle collision, FIXED_PRIO = 0, after reset: S0 reads 0x10, S1 reads 0x20 -> M_HADDR = 0x10 in cycle 0, then 0x20 in cycle 1; S1_HREADYOUT low for exactly 1 cycle; each port gets its own data.
- Round-robin fairness: both ports issue back-to-back reads for 8 transfers -> slave sees alternating 0,1,0,1... ownership, 4 transfers per port. With FIXED_PRIO = 1, all S0 transfers precede S1's.
- Slave wait states: M_HREADYOUT low for 2 cycles during an S0 write while S1 requests -> S1 captured, M_* unchanged during stall, S1 granted on the cycle M_HREADYOUT returns 1, M_HWDATA follows own_id.
- Error forwarding: slave gives 2-cycle ERROR on an S1 access -> S1_HRESP = 1 on both cycles, S0_HRESP = 0, S0's pending request granted afterwards.
- Reset mid-operation: assert HRESETn with S1 pending -> M_HSEL = 0, both HREADYOUT = 1, no replay after release.
